// File: rtl/branch_predict_unit.sv
// Branch target buffer with 2-bit counters plus control-flow resolution and redirect.
// Optional performance counters are enabled by defining BRANCH_PERF_CNT_EN.
module branch_predict_unit #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            f_valid,
  input  logic [XLEN-1:0] f_pc,
  output logic            p_valid,
  output logic            p_taken,
  output logic [XLEN-1:0] p_target,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs_1,
  input  logic [XLEN-1:0] ex_rs_2,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_func_3,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            r_valid,
  output logic            r_taken,
  output logic            r_mispredict,
  output logic [XLEN-1:0] r_target,
  output logic [XLEN-1:0] r_link,
  input  logic            perf_clr,
  output logic [31:0]     cnt_branch,
  output logic [31:0]     cnt_mispredict
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic             tbl_valid  [DEPTH];
  logic [TAG_W-1:0] tbl_tag    [DEPTH];
  logic [XLEN-1:0]  tbl_target [DEPTH];
  logic [1:0]       tbl_ctr    [DEPTH];

  logic [IDX_W-1:0] f_idx, ex_idx;
  logic [TAG_W-1:0] f_tag, ex_tag;
  logic             f_req, f_pred, ex_hit;
  logic             is_jal, is_jalr, is_br, is_cf, br_known, br_cond;
  logic             taken, mispredict, entry_wr, ctr_wr;
  logic [XLEN-1:0]  jalr_sum, target, link;
  logic [1:0]       ctr_next;
  logic             unused_sig;

  assign f_idx  = f_pc[IDX_W+1:2];
  assign f_tag  = f_pc[XLEN-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[XLEN-1:IDX_W+2];
  assign f_req  = f_valid && !flush;
  assign f_pred = tbl_valid[f_idx] && (tbl_tag[f_idx] == f_tag) && tbl_ctr[f_idx][1];
  assign ex_hit = tbl_valid[ex_idx] && (tbl_tag[ex_idx] == ex_tag);
  assign unused_sig = ^{f_pc[1:0], perf_clr};

  // Nonblocking table writes give read-before-write for a same-cycle lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid  <= 1'b0;
      p_taken  <= 1'b0;
      p_target <= '0;
    end else begin
      p_valid  <= f_req;
      p_taken  <= f_req && f_pred;
      p_target <= (f_req && f_pred) ? tbl_target[f_idx] : '0;
    end
  end

  always_comb begin
    is_jal   = ex_valid && (ex_opcode == OP_JAL);
    is_jalr  = ex_valid && (ex_opcode == OP_JALR);
    is_br    = ex_valid && (ex_opcode == OP_BRANCH);
    is_cf    = is_jal || is_jalr || is_br;
    br_known = (ex_func_3[2:1] != 2'b01);
    case (ex_func_3)
      3'b000:  br_cond = (ex_rs_1 == ex_rs_2);
      3'b001:  br_cond = (ex_rs_1 != ex_rs_2);
      3'b100:  br_cond = ($signed(ex_rs_1) <  $signed(ex_rs_2));
      3'b101:  br_cond = ($signed(ex_rs_1) >= $signed(ex_rs_2));
      3'b110:  br_cond = (ex_rs_1 <  ex_rs_2);
      3'b111:  br_cond = (ex_rs_1 >= ex_rs_2);
      default: br_cond = 1'b0;
    endcase
    taken      = is_jal || is_jalr || (is_br && br_cond);
    jalr_sum   = ex_rs_1 + ex_imm;
    target     = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);
    link       = ex_pc + XLEN'(4);
    mispredict = (taken != ex_pred_taken) || (taken && (target != ex_pred_target));
  end

  // Jumps always (re)allocate as strongly taken; branches train only on known conditions.
  always_comb begin
    entry_wr = is_jal || is_jalr || (is_br && br_known && taken);
    ctr_wr   = 1'b0;
    ctr_next = tbl_ctr[ex_idx];
    if (is_jal || is_jalr) begin
      ctr_wr   = 1'b1;
      ctr_next = 2'b11;
    end else if (is_br && br_known && ex_hit) begin
      ctr_wr = 1'b1;
      if (taken) ctr_next = (tbl_ctr[ex_idx] == 2'b11) ? 2'b11 : tbl_ctr[ex_idx] + 2'd1;
      else       ctr_next = (tbl_ctr[ex_idx] == 2'b00) ? 2'b00 : tbl_ctr[ex_idx] - 2'd1;
    end else if (is_br && br_known && taken) begin
      ctr_wr   = 1'b1;
      ctr_next = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_valid[i] <= 1'b0;
        tbl_ctr[i]   <= 2'b01;
      end
    end else begin
      if (entry_wr) tbl_valid[ex_idx] <= 1'b1;
      if (ctr_wr)   tbl_ctr[ex_idx]   <= ctr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (entry_wr) begin
      tbl_tag[ex_idx]    <= ex_tag;
      tbl_target[ex_idx] <= target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_taken      <= 1'b0;
      r_mispredict <= 1'b0;
      r_target     <= '0;
      r_link       <= '0;
    end else begin
      r_valid      <= is_cf;
      r_taken      <= is_cf && taken;
      r_mispredict <= is_cf && mispredict;
      r_target     <= is_cf ? (taken ? target : link) : '0;
      r_link       <= is_cf ? link : '0;
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_branch     <= '0;
      cnt_mispredict <= '0;
    end else if (perf_clr) begin
      cnt_branch     <= '0;
      cnt_mispredict <= '0;
    end else begin
      if (is_cf)               cnt_branch     <= cnt_branch + 32'd1;
      if (is_cf && mispredict) cnt_mispredict <= cnt_mispredict + 32'd1;
    end
  end
`else
  assign cnt_branch     = '0;
  assign cnt_mispredict = '0;
`endif

endmodule
